maxnet_n: RTL and testbench

Parametrised iterative winner-take-all (MAXNET) engine: accepts N unsigned W-bit candidates and an unsigned fixed-point inhibition weight epsilon, then mutually inhibits the candidates until at most one survives. It reports the surviving candidate's original value and index. Every candidate is updated in parallel each cycle. Termination is bounded by an iteration limit, and the block reports timeout (unresolved tie) and all-zero conditions. It replaces the fixed four-input 32-bit max finder in the datapath and is driven by the same start/done controller handshake.

---
 rtl/maxnet_n.sv | 123 ++++++++++++
 tb/tb_maxnet_n.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/maxnet_n.sv
// maxnet_n: iterative winner-take-all over N unsigned candidates with fixed-point
// mutual inhibition; reports the surviving candidate's original value and index.
//
// state | meaning
// IDLE  | waiting for start, outputs at reset value
// RUN   | one parallel inhibition step per cycle until <=1 survivor or iteration limit
// DONE  | results held, done high, start accepted for a new run
module maxnet_n #(
    parameter int N        = 4,
    parameter int W        = 32,
    parameter int FRAC     = 16,
    parameter int MAX_ITER = 255,
    localparam int CW      = $clog2(MAX_ITER + 1),
    localparam int IW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   epsilon,
    input  logic [N*W-1:0] nums,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   max,
    output logic [IW-1:0]  winner,
    output logic [CW-1:0]  iters,
    output logic           timeout,
    output logic           none
);
    localparam int SW = W + IW;
    localparam int PW = W + SW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] ITER_LIM = CW'(MAX_ITER);

    logic [1:0]    state;
    logic [W-1:0]  orig     [N];
    logic [W-1:0]  act      [N];
    logic [W-1:0]  act_next [N];
    logic [SW-1:0] other    [N];
    logic [PW-1:0] scaled   [N];
    logic [W-1:0]  eps;
    logic [SW-1:0] sum;
    logic [IW:0]   nz_cnt;
    logic [IW-1:0] lead;

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    // lead is the lowest-index survivor, 0 when nothing survives
    always_comb begin
        sum    = '0;
        nz_cnt = '0;
        lead   = '0;
        for (int i = 0; i < N; i++) begin
            sum    = sum + SW'(act[i]);
            nz_cnt = nz_cnt + (IW + 1)'(act[i] != '0);
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (act[i] != '0) lead = IW'(i);
        end
    end

    // Inhibition is compared at full product width so a large penalty always clears the channel
    always_comb begin
        for (int i = 0; i < N; i++) begin
            other[i]    = sum - SW'(act[i]);
            scaled[i]   = (PW'(eps) * PW'(other[i])) >> FRAC;
            act_next[i] = (PW'(act[i]) > scaled[i]) ? act[i] - scaled[i][W-1:0] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            eps     <= '0;
            max     <= '0;
            winner  <= '0;
            iters   <= '0;
            timeout <= 1'b0;
            none    <= 1'b0;
            for (int i = 0; i < N; i++) begin
                orig[i] <= '0;
                act[i]  <= '0;
            end
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        for (int i = 0; i < N; i++) begin
                            orig[i] <= nums[i*W +: W];
                            act[i]  <= nums[i*W +: W];
                        end
                        eps     <= epsilon;
                        iters   <= '0;
                        timeout <= 1'b0;
                        none    <= 1'b0;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (nz_cnt <= (IW + 1)'(1)) begin
                        state  <= S_DONE;
                        winner <= lead;
                        none   <= (nz_cnt == '0);
                        max    <= (nz_cnt == '0) ? '0 : orig[lead];
                    end else if (iters == ITER_LIM) begin
                        state   <= S_DONE;
                        timeout <= 1'b1;
                        winner  <= lead;
                        max     <= orig[lead];
                    end else begin
                        for (int i = 0; i < N; i++) act[i] <= act_next[i];
                        iters <= iters + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_maxnet_n.sv
// tb_maxnet_n: table vectors, directed handshake sequences and randomized runs
// checked against a plain-arithmetic MAXNET model.
module tb_maxnet_n;
    localparam int N        = 4;
    localparam int W        = 16;
    localparam int FRAC     = 8;
    localparam int MAX_ITER = 20;
    localparam int CW       = $clog2(MAX_ITER + 1);
    localparam int IW       = $clog2(N);

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   epsilon = '0;
    logic [N*W-1:0] nums = '0;
    logic           busy, done, timeout, none;
    logic [W-1:0]   max;
    logic [IW-1:0]  winner;
    logic [CW-1:0]  iters;

    int n_checks = 0;
    int n_fail   = 0;

    maxnet_n #(.N(N), .W(W), .FRAC(FRAC), .MAX_ITER(MAX_ITER)) dut (
        .clk(clk), .rst(rst), .start(start), .epsilon(epsilon), .nums(nums),
        .busy(busy), .done(done), .max(max), .winner(winner), .iters(iters),
        .timeout(timeout), .none(none)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*W-1:0] nv;
        logic [W-1:0]   ev;
        longint         mx;
        longint         win;
        longint         it;
        longint         to;
        longint         nn;
        longint         lat;
    } vec_t;

    task automatic check(input string name, input longint act_v, input longint exp_v);
        n_checks++;
        if (act_v != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act_v, exp_v);
        end
    endtask

    // Reference: iterate the inhibition rule with integer arithmetic until resolved
    function automatic vec_t model(input logic [N*W-1:0] nv, input logic [W-1:0] ev);
        longint a[N];
        longint nxt[N];
        longint s, p, k;
        vec_t r;
        r.nv = nv;
        r.ev = ev;
        for (int i = 0; i < N; i++) a[i] = longint'(nv[i*W +: W]);
        r.it = 0;
        k = 0;
        while (1) begin
            k = 0;
            s = 0;
            for (int i = 0; i < N; i++) begin
                if (a[i] != 0) k++;
                s += a[i];
            end
            if (k <= 1 || r.it == MAX_ITER) break;
            for (int i = 0; i < N; i++) begin
                p = (longint'(ev) * (s - a[i])) / (longint'(1) << FRAC);
                nxt[i] = (a[i] > p) ? a[i] - p : 0;
            end
            a = nxt;
            r.it++;
        end
        r.win = 0;
        for (int i = N - 1; i >= 0; i--) if (a[i] != 0) r.win = i;
        r.to  = (k >= 2) ? 1 : 0;
        r.nn  = (k == 0) ? 1 : 0;
        r.mx  = (k == 0) ? 0 : longint'(nv[r.win*W +: W]);
        r.lat = r.it + 1;
        return r;
    endfunction

    // Start a run, scramble the inputs afterwards, and wait (bounded) for done
    task automatic do_run(input logic [N*W-1:0] nv, input logic [W-1:0] ev, output longint lat);
        @(negedge clk);
        nums    = nv;
        epsilon = ev;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        nums    = ~nv;
        epsilon = ~ev;
        check("busy_after_start", 64'(busy), 1);
        check("done_low_after_start", 64'(done), 0);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
        end
        check("done_reached", 64'(done), 1);
        check("busy_low_in_done", 64'(busy), 0);
    endtask

    task automatic check_res(input string tag, input vec_t e, input longint lat);
        check({tag, "_max"},     64'(max),     e.mx);
        check({tag, "_winner"},  64'(winner),  e.win);
        check({tag, "_iters"},   64'(iters),   e.it);
        check({tag, "_timeout"}, 64'(timeout), e.to);
        check({tag, "_none"},    64'(none),    e.nn);
        check({tag, "_latency"}, lat,          e.lat);
    endtask

    vec_t   vecs[8];
    vec_t   s1;
    vec_t   e;
    longint lat;

    initial begin
        //            nums ch3..ch0                                  eps       max win it to nn lat
        vecs[0] = '{{16'd40, 16'd30, 16'd20, 16'd10},               16'h0020,    40, 3,  8, 0, 0,  9};
        vecs[1] = '{{16'd0,  16'd77, 16'd0,  16'd0},                16'h0020,    77, 2,  0, 0, 0,  1};
        vecs[2] = '{{16'd0,  16'd0,  16'd0,  16'd0},                16'h0020,     0, 0,  0, 0, 1,  1};
        vecs[3] = '{{16'd0,  16'd0,  16'd50, 16'd50},               16'h0020,    50, 0, 20, 1, 0, 21};
        vecs[4] = '{{16'd9,  16'd0,  16'd0,  16'd0},                16'h0020,     9, 3,  0, 0, 0,  1};
        vecs[5] = '{{16'd0,  16'd0,  16'd2,  16'd1},                16'h0000,     1, 0, 20, 1, 0, 21};
        vecs[6] = '{{16'd0,  16'd0,  16'd5,  16'd3},                16'h0100,     5, 1,  1, 0, 0,  2};
        vecs[7] = '{{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},       16'hFFFF,     0, 0,  1, 0, 1,  2};
        s1 = vecs[0];

        #1;
        check("rst_busy",    64'(busy),    0);
        check("rst_done",    64'(done),    0);
        check("rst_max",     64'(max),     0);
        check("rst_winner",  64'(winner),  0);
        check("rst_iters",   64'(iters),   0);
        check("rst_timeout", 64'(timeout), 0);
        check("rst_none",    64'(none),    0);
        #12;
        rst = 1'b1;

        for (int v = 0; v < 8; v++) begin
            do_run(vecs[v].nv, vecs[v].ev, lat);
            check_res($sformatf("vec%0d", v), vecs[v], lat);
        end

        // start re-pulsed mid-run must be ignored
        @(negedge clk);
        nums = s1.nv; epsilon = s1.ev; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        lat = 0;
        repeat (2) begin @(posedge clk); #1; lat++; end
        nums = {16'd1, 16'd1, 16'd1, 16'd1};
        start = 1'b1;
        @(posedge clk); #1; lat++; start = 1'b0;
        while (lat < 100 && !done) begin @(posedge clk); #1; lat++; end
        check_res("restart_ignored", s1, lat);

        // new start accepted from DONE
        do_run({16'd0, 16'd0, 16'd0, 16'd5}, 16'h0020, lat);
        e = '{{16'd0, 16'd0, 16'd0, 16'd5}, 16'h0020, 5, 0, 0, 0, 0, 1};
        check_res("from_done", e, lat);

        // asynchronous reset mid-run
        @(negedge clk);
        nums = s1.nv; epsilon = s1.ev; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("abort_busy",    64'(busy),    0);
        check("abort_done",    64'(done),    0);
        check("abort_max",     64'(max),     0);
        check("abort_iters",   64'(iters),   0);
        check("abort_winner",  64'(winner),  0);
        check("abort_timeout", 64'(timeout), 0);
        @(negedge clk);
        rst = 1'b1;
        do_run(s1.nv, s1.ev, lat);
        check_res("after_reset", s1, lat);

        // start held high: each run shows done for exactly one cycle
        @(negedge clk);
        nums = {16'd0, 16'd77, 16'd0, 16'd0}; epsilon = 16'h0020; start = 1'b1;
        @(posedge clk); #1;
        check("hold_s0_done", 64'(done), 0);
        @(posedge clk); #1;
        check("hold_s1_done", 64'(done), 1);
        check("hold_s1_max",  64'(max),  77);
        @(posedge clk); #1;
        check("hold_s2_done", 64'(done), 0);
        check("hold_s2_busy", 64'(busy), 1);
        @(posedge clk); #1;
        check("hold_s3_done", 64'(done), 1);
        start = 1'b0;

        for (int r = 0; r < 40; r++) begin
            logic [N*W-1:0] nv;
            logic [W-1:0]   ev;
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 3))
                    0:       nv[i*W +: W] = '0;
                    1:       nv[i*W +: W] = W'($urandom_range(0, 255));
                    default: nv[i*W +: W] = W'($urandom_range(0, 65535));
                endcase
            end
            if ($urandom_range(0, 4) == 0) nv[W +: W] = nv[0 +: W];
            case ($urandom_range(0, 2))
                0:       ev = W'($urandom_range(0, 64));
                1:       ev = W'($urandom_range(0, 1023));
                default: ev = W'($urandom_range(0, 65535));
            endcase
            e = model(nv, ev);
            do_run(nv, ev, lat);
            check_res($sformatf("rand%0d", r), e, lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
